// File: rtl/taxi_pkg.sv
// Shared taxi-meter definitions: debounce and stretcher state
// encodings plus default timing parameters.
package taxi_pkg;

    localparam int DEBOUNCE_CYC_DEF = 1000;
    localparam int PULSE_W_DEF      = 4;
    localparam int STOP_TIMEOUT_DEF = 50_000_000;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_RISE_CHK,
        DB_HIGH,
        DB_FALL_CHK
    } db_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } str_state_e;

endpackage

// File: rtl/wheel_debounce.sv
// Level debouncer emitting a one-cycle tick on each accepted rising level.
// Ports: clk, rst (sync, active high), din (already synchronised), tick.
module wheel_debounce
    import taxi_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    db_state_e     state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DB_LOW;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            unique case (state)
                DB_LOW: begin
                    if (din) begin
                        state <= DB_RISE_CHK;
                        cnt   <= '0;
                    end
                end
                DB_RISE_CHK: begin
                    if (!din) begin
                        state <= DB_LOW;
                    end else if (cnt == LAST) begin
                        state <= DB_HIGH;
                        tick  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DB_HIGH: begin
                    if (!din) begin
                        state <= DB_FALL_CHK;
                        cnt   <= '0;
                    end
                end
                DB_FALL_CHK: begin
                    if (din) begin
                        state <= DB_HIGH;
                    end else if (cnt == LAST) begin
                        state <= DB_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= DB_LOW;
            endcase
        end
    end

endmodule

// File: rtl/wheel_pulse_gen.sv
// Wheel sensor to 10 m strobe: sync, debounce, edge count, stretch, stop detect.
// Ports: clk, rst, wheel_raw, en, pulses_per_10m -> ten_meter_pulse, moving, overrun.
module wheel_pulse_gen
    import taxi_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PULSE_W      = PULSE_W_DEF,
    parameter int STOP_TIMEOUT = STOP_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wheel_raw,
    input  logic       en,
    input  logic [7:0] pulses_per_10m,
    output logic       ten_meter_pulse,
    output logic       moving,
    output logic       overrun
);

    localparam int PCW = $clog2(PULSE_W + 1);
    localparam logic [PCW-1:0] PLAST = PCW'(PULSE_W - 1);
    localparam int TW = $clog2(STOP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(STOP_TIMEOUT);

    logic sync1, sync2;
    logic wheel_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= wheel_raw;
            sync2 <= sync1;
        end
    end

    wheel_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .din (sync2),
        .tick(wheel_tick)
    );

    // Edge counter; >= makes a lowered target fire on the next tick
    logic [7:0] cnt;
    logic [7:0] eff;
    logic       at_end;
    logic       ev;

    assign eff    = (pulses_per_10m == 8'd0) ? 8'd1 : pulses_per_10m;
    assign at_end = cnt >= (eff - 8'd1);
    assign ev     = wheel_tick & en & at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wheel_tick && en) begin
            cnt <= at_end ? 8'd0 : cnt + 8'd1;
        end
    end

    // Stretcher: one event may wait in pending; a further one is lost
    str_state_e     st;
    logic [PCW-1:0] pw_cnt;
    logic           pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            st              <= ST_IDLE;
            pw_cnt          <= '0;
            pending         <= 1'b0;
            ten_meter_pulse <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (ev) begin
                        st              <= ST_PULSE;
                        pw_cnt          <= '0;
                        ten_meter_pulse <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (ev) begin
                        if (pending) overrun <= 1'b1;
                        else pending <= 1'b1;
                    end
                    if (pw_cnt == PLAST) begin
                        st              <= ST_GAP;
                        pw_cnt          <= '0;
                        ten_meter_pulse <= 1'b0;
                    end else begin
                        pw_cnt <= pw_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (pw_cnt == PLAST) begin
                        if (pending || ev) begin
                            // a same-cycle event replaces the consumed one
                            st              <= ST_PULSE;
                            pw_cnt          <= '0;
                            ten_meter_pulse <= 1'b1;
                            pending         <= pending & ev;
                        end else begin
                            st <= ST_IDLE;
                        end
                    end else begin
                        pw_cnt <= pw_cnt + 1'b1;
                        if (ev) begin
                            if (pending) overrun <= 1'b1;
                            else pending <= 1'b1;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Stop timer starts saturated so moving stays low until a first tick
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= TMAX;
        end else if (wheel_tick) begin
            timer <= '0;
        end else if (timer != TMAX) begin
            timer <= timer + 1'b1;
        end
    end

    assign moving = timer < TMAX;

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Randomised bench for wheel_pulse_gen against a timeline-based model.
// Parameters chosen so pending, overrun and timeout are all reachable.
module tb_wheel_pulse_gen;

    localparam int D  = 1;
    localparam int PW = 3;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wheel_raw = 1'b0;
    logic       en = 1'b0;
    logic [7:0] pulses_per_10m = 8'd3;
    logic       ten_meter_pulse;
    logic       moving;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    wheel_pulse_gen #(
        .DEBOUNCE_CYC(D),
        .PULSE_W     (PW),
        .STOP_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wheel_raw      (wheel_raw),
        .en             (en),
        .pulses_per_10m (pulses_per_10m),
        .ten_meter_pulse(ten_meter_pulse),
        .moving         (moving),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: levels accepted after D+1 equal synced samples,
    // pulses tracked as start times on an edge-index timeline.
    int m_s1, m_s2, m_lvl, m_run, m_tick;
    int m_cnt, m_wait, m_nxt, m_start, m_ovr, m_last, m_seen;
    int k = 0;
    int n_ovr_events = 0;
    int n_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d",
                     tag, k, got, exp);
        end
    endtask

    task automatic start_pulse();
        m_start = k;
        m_nxt   = k + 2 * PW;
        n_pulses++;
    endtask

    task automatic model_step();
        int tick_v, ev, eff;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_tick = 0;
            m_cnt = 0; m_wait = 0; m_nxt = 0; m_start = -1000;
            m_ovr = 0; m_last = 0; m_seen = 0;
            return;
        end
        tick_v = m_tick;
        m_tick = 0;
        if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
                m_lvl = m_s2;
                m_run = 0;
                if (m_lvl == 1) m_tick = 1;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(wheel_raw);
        ev = 0;
        if (tick_v == 1 && en) begin
            eff = (pulses_per_10m == 0) ? 1 : int'(pulses_per_10m);
            if (m_cnt + 1 >= eff) begin
                ev = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (m_wait == 1 && k == m_nxt) begin
            start_pulse();
            if (ev == 0) m_wait = 0;
        end else if (ev == 1) begin
            if (k >= m_nxt) start_pulse();
            else if (m_wait == 0) m_wait = 1;
            else begin
                m_ovr = 1;
                n_ovr_events++;
            end
        end
        if (tick_v == 1) begin
            m_last = k;
            m_seen = 1;
        end
    endtask

    task automatic cyc();
        int exp_p, exp_m;
        @(posedge clk);
        model_step();
        #1;
        exp_p = (k >= m_start && k < m_start + PW) ? 1 : 0;
        exp_m = (m_seen == 1 && (k - m_last) < TO) ? 1 : 0;
        chk("ten_meter_pulse", 32'(ten_meter_pulse), 32'(exp_p));
        chk("moving", 32'(moving), 32'(exp_m));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        k++;
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic edges(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            wheel_raw = 1'b1;
            hold(hi);
            wheel_raw = 1'b0;
            hold(lo);
        end
    endtask

    initial begin
        rst = 1'b1;
        hold(3);
        rst = 1'b0;
        en = 1'b1;
        hold(4);

        // single-cycle glitch must not count
        pulses_per_10m = 8'd1;
        edges(1, 1, 10);

        // basic count of three
        pulses_per_10m = 8'd3;
        edges(6, 6, 6);

        // lower the target mid-count, then zero means every edge
        pulses_per_10m = 8'd10;
        edges(7, 5, 5);
        pulses_per_10m = 8'd5;
        edges(1, 5, 5);
        pulses_per_10m = 8'd0;
        edges(3, 5, 12);

        // fastest possible ticks: pending, same-cycle refill, overrun
        pulses_per_10m = 8'd1;
        edges(12, 2, 2);
        hold(20);

        // reset while pulsing with an event waiting
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        edges(3, 2, 2);
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(20);

        // disabled counting still keeps moving alive, then timeout
        edges(2, 4, 4);
        en = 1'b0;
        edges(5, 4, 4);
        hold(TO + 10);
        en = 1'b1;

        // random traffic
        for (int seg = 0; seg < 600; seg++) begin
            int r;
            r = int'($urandom_range(0, 9));
            en = (r < 8);
            r = int'($urandom_range(0, 5));
            if (r == 0) pulses_per_10m = 8'd0;
            else if (r == 1) pulses_per_10m = 8'd1;
            else if (r == 2) pulses_per_10m = 8'd2;
            else pulses_per_10m = 8'($urandom_range(1, 12));
            rst = ($urandom_range(0, 99) == 0);
            wheel_raw = $urandom_range(0, 1) == 1;
            hold(int'($urandom_range(1, 6)));
            rst = 1'b0;
            if ($urandom_range(0, 59) == 0) hold(TO + 5);
        end

        chk("overrun_events_seen", 32'(n_ovr_events > 0), 32'd1);
        chk("pulses_seen", 32'(n_pulses > 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
